// File: rtl/pwm_pkg.sv
// Shared constants for the PWM sequencer and the SPI register bank that feeds it.
//   - Timebase / channel geometry constants.
//   - SPI register addresses of the five configuration bytes.
//   - pwm_level(): per-channel compare used by the output stage.
package pwm_pkg;

  localparam int PWM_CNT_W        = 8;
  localparam int PWM_NUM_CH       = 16;
  localparam int PWM_PRE_W        = 16;
  localparam logic [7:0] PWM_DUTY_FULL = 8'hFF;
  localparam int PWM_STAGGER_STEP = 16;

  // SPI register bank addresses
  localparam logic [7:0] REG_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] REG_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] REG_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] REG_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] REG_PWM_DUTY    = 8'h04;

  // Full-scale duty is forced high so a 100 % channel never shows a
  // one-count low pulse when the count reaches 255.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cc,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == PWM_DUTY_FULL) ? 1'b1 : (cc < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 8-bit PWM count, wrap-tick detect and
// period_start pulse.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cnt           : PWM count, advances once per PRESCALE clk, wraps 255->0
//   wrap_tick     : combinational, high on the tick that wraps cnt 255->0
//   period_start  : registered one-clk pulse aligned with the first clk on
//                   which the controller's registered outputs reflect cnt=0
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] cnt,
  output logic                 wrap_tick,
  output logic                 period_start
);

  localparam logic [PWM_PRE_W-1:0] PRE_MAX = PWM_PRE_W'(PRESCALE - 1);

  logic [PWM_PRE_W-1:0] pre;
  logic                 tick;
  logic                 wrap_q;

  assign tick      = (pre == PRE_MAX);
  assign wrap_tick = tick && (cnt == {PWM_CNT_W{1'b1}});

  // wrap_q marks the clk on which cnt=0 sits in the counter register; the
  // channel outputs are registered from it one clk later, so period_start
  // takes one more stage to line up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre          <= '0;
      cnt          <= '0;
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre          <= tick ? '0 : pre + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
      wrap_q       <= wrap_tick;
      period_start <= wrap_q;
    end
  end

endmodule

// File: rtl/pwm_controller.sv
// PWM sequencer for 16 outputs configured over SPI.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   en_reg_out_7_0/15_8             : per-channel output enable (not shadowed)
//   en_reg_pwm_7_0/15_8             : per-channel PWM mode (shadowed)
//   pwm_duty_cycle                  : shared duty, 0x00 = 0 %, 0xFF = 100 %
//   out_7_0/out_15_8                : registered channel outputs
//   period_start                    : one-clk pulse per PWM period
// PWM mode and duty are captured into shadows on the wrap tick only, so a
// period always completes with the settings it started with.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13,
  parameter int STAGGER  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  logic [PWM_NUM_CH-1:0] en_out;
  logic [PWM_NUM_CH-1:0] en_pwm;
  logic [PWM_NUM_CH-1:0] sh_pwm;
  logic [PWM_CNT_W-1:0]  sh_duty;
  logic [PWM_CNT_W-1:0]  cnt;
  logic                  wrap_tick;
  logic [PWM_NUM_CH-1:0] ch_next;
  logic [PWM_NUM_CH-1:0] out_q;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt         (cnt),
    .wrap_tick   (wrap_tick),
    .period_start(period_start)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pwm  <= '0;
      sh_duty <= '0;
    end else if (wrap_tick) begin
      sh_pwm  <= en_pwm;
      sh_duty <= pwm_duty_cycle;
    end
  end

  // Per-channel compare: with STAGGER, channel i sees the count advanced
  // by 16*i so the high windows of neighbouring channels do not coincide.
  for (genvar i = 0; i < PWM_NUM_CH; i++) begin : g_ch
    localparam logic [PWM_CNT_W-1:0] OFFS =
      PWM_CNT_W'((STAGGER != 0) ? PWM_STAGGER_STEP * i : 0);
    logic [PWM_CNT_W-1:0] cc;
    assign cc = cnt + OFFS;
    // Enable is applied here, unshadowed, so a disable lands next clk.
    assign ch_next[i] = en_out[i] & (sh_pwm[i] ? pwm_level(cc, sh_duty) : 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= ch_next;
  end

  assign out_7_0  = out_q[7:0];
  assign out_15_8 = out_q[15:8];

endmodule

// File: tb/tb_pwm_controller.sv
// Directed bench for pwm_controller. Two instances share the inputs:
//   dut   : PRESCALE=2, STAGGER=0 (period 512 clk)
//   dut_s : PRESCALE=1, STAGGER=1 (period 256 clk)
// Timing reference: with rst_n released at a negedge, the count wraps on
// posedge number 256*PRESCALE; the outputs and period_start reflect cnt=0
// one clk later, i.e. at posedge 256*PRESCALE+1.
module tb_pwm_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] en_out_lo = '0, en_out_hi = '0;
  logic [7:0] en_pwm_lo = '0, en_pwm_hi = '0;
  logic [7:0] duty = '0;
  logic [7:0] out_lo, out_hi, s_out_lo, s_out_hi;
  logic       ps, s_ps;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_controller #(.PRESCALE(2), .STAGGER(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
    .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
    .pwm_duty_cycle(duty),
    .out_7_0(out_lo), .out_15_8(out_hi), .period_start(ps)
  );

  pwm_controller #(.PRESCALE(1), .STAGGER(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
    .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
    .pwm_duty_cycle(duty),
    .out_7_0(s_out_lo), .out_15_8(s_out_hi), .period_start(s_ps)
  );

  typedef struct {
    logic [15:0] en_out;
    logic [7:0]  duty;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_out_lo = eo[7:0];
    en_out_hi = eo[15:8];
    en_pwm_lo = ep[7:0];
    en_pwm_hi = ep[15:8];
    duty      = d;
  endtask

  // Advance to the next negedge on which the chosen period_start is high.
  task automatic wait_ps(input bit use_s, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      seen = use_s ? s_ps : ps;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Called on the negedge where dut's period_start is high (k=0). Checks
  // out_7_0[0] over one 512-clk period: high for k < exp_high. The duty
  // input is rewritten at k == chg_at, which must not affect this period.
  task automatic run_window(input string name, input int exp_high,
                            input int chg_at, input logic [7:0] chg_duty);
    int mism = 0;
    int ps_cnt = 0;
    for (int k = 0; k < 512; k++) begin
      if (out_lo[0] !== (k < exp_high)) mism++;
      if (ps) ps_cnt++;
      if (k == chg_at) duty = chg_duty;
      @(negedge clk);
    end
    check({name, "_shape_errs"}, 32'(mism), 32'd0);
    check({name, "_ps_width"}, 32'(ps_cnt), 32'd1);
    check({name, "_ps_next"}, 32'(ps), 32'd1);
  endtask

  initial begin
    int first, first_s, last, n_ps, n_ps_s;
    int mism, ovl, lo;
    logic [15:0] exp_w;

    // Static-mode vectors: PWM mode off, so each output is just its enable.
    vecs[0] = '{16'hFFFF, 8'h00, 8'hFF, 8'hFF};
    vecs[1] = '{16'h0000, 8'h55, 8'h00, 8'h00};
    vecs[2] = '{16'h0001, 8'h80, 8'h01, 8'h00};
    vecs[3] = '{16'h8000, 8'hFF, 8'h00, 8'h80};
    vecs[4] = '{16'hA55A, 8'h10, 8'h5A, 8'hA5};
    vecs[5] = '{16'h00FF, 8'h00, 8'hFF, 8'h00};
    vecs[6] = '{16'hFF00, 8'h7F, 8'h00, 8'hFF};
    vecs[7] = '{16'h1234, 8'hC3, 8'h34, 8'h12};

    // ---- reset ----
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_lo", 32'(out_lo), 32'h00);
    check("rst_out_hi", 32'(out_hi), 32'h00);
    check("rst_ps", 32'(ps), 32'd0);
    check("rst_s_out", 32'({s_out_hi, s_out_lo}), 32'h0000);
    check("rst_s_ps", 32'(s_ps), 32'd0);
    rst_n = 1'b1;

    // ---- period_start placement and spacing ----
    first = 0; first_s = 0; last = 0; n_ps = 0; n_ps_s = 0;
    for (int n = 1; n <= 1200; n++) begin
      @(negedge clk);
      if (ps) begin
        if (first == 0) first = n;
        last = n;
        n_ps++;
      end
      if (s_ps) begin
        if (first_s == 0) first_s = n;
        n_ps_s++;
      end
      if (out_lo !== 8'h00 || out_hi !== 8'h00) mism++;
    end
    check("first_ps", 32'(first), 32'd513);
    check("second_ps", 32'(last), 32'd1025);
    check("ps_count", 32'(n_ps), 32'd2);
    check("first_ps_s", 32'(first_s), 32'd257);
    check("ps_count_s", 32'(n_ps_s), 32'd4);
    check("idle_outputs_zero", 32'(mism), 32'd0);

    // ---- static output vectors ----
    for (int i = 0; i < 8; i++) begin
      set_inputs(vecs[i].en_out, 16'h0000, vecs[i].duty);
      @(negedge clk);
      check($sformatf("vec%0d_lo", i), 32'(out_lo), 32'(vecs[i].exp_lo));
      check($sformatf("vec%0d_hi", i), 32'(out_hi), 32'(vecs[i].exp_hi));
      check($sformatf("vec%0d_s_lo", i), 32'(s_out_lo), 32'(vecs[i].exp_lo));
      check($sformatf("vec%0d_s_hi", i), 32'(s_out_hi), 32'(vecs[i].exp_hi));
    end
    set_inputs(16'hFFFF, 16'h0000, 8'h00);
    repeat (5) @(negedge clk);
    check("static_hold", 32'({out_hi, out_lo}), 32'hFFFF);

    // ---- PWM on channel 0, duty sequence ----
    wait_ps(1'b0, "align0");
    set_inputs(16'h0001, 16'h0001, 8'h80);
    wait_ps(1'b0, "align1");
    run_window("duty80", 256, 300, 8'h00);
    run_window("duty00", 0, 300, 8'hFF);
    run_window("dutyFF", 512, 300, 8'h40);
    run_window("duty40_midchange", 128, 100, 8'hC0);
    // Now in the 0xC0 period: cnt=100 at k=200 is high only with 0xC0.
    repeat (200) @(negedge clk);
    check("dutyC0_applied", 32'(out_lo[0]), 32'd1);
    en_out_lo = 8'h00;
    @(negedge clk);
    check("disable_next_clk", 32'(out_lo[0]), 32'd0);

    // ---- staggered channels ----
    set_inputs(16'hFFFF, 16'hFFFF, 8'h10);
    wait_ps(1'b1, "stag_align0");
    wait_ps(1'b1, "stag_align1");
    mism = 0; ovl = 0;
    for (int k = 0; k < 256; k++) begin
      exp_w = '0;
      for (int i = 0; i < 16; i++) begin
        lo = (256 - 16 * i) % 256;  // channel i high for cnt in [lo, lo+15] mod 256
        exp_w[i] = (((k - lo + 256) % 256) < 16);
      end
      if ({s_out_hi, s_out_lo} !== exp_w) mism++;
      if ($countones({s_out_hi, s_out_lo}) != 1) ovl++;
      @(negedge clk);
    end
    check("stagger_pattern_errs", 32'(mism), 32'd0);
    check("stagger_overlap_errs", 32'(ovl), 32'd0);
    check("stagger_ps_next", 32'(s_ps), 32'd1);
    repeat (40) @(negedge clk);
    check("stagger_k40", 32'({s_out_hi, s_out_lo}), 32'h4000);

    // ---- asynchronous reset mid-run ----
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_s_out", 32'({s_out_hi, s_out_lo}), 32'h0000);
    check("async_rst_out", 32'({out_hi, out_lo}), 32'h0000);
    check("async_rst_ps", 32'({s_ps, ps}), 32'd0);
    #20 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
